// File: rtl/dmix_rate_pkg.sv
// Shared constants, rate codes, FSM states and the period classifier for the
// LRCK rate detector.
package dmix_rate_pkg;

    localparam int              CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_MAX  = 10'd1023;
    localparam logic [CNT_W-1:0] NOM_48K  = 10'd512;
    localparam logic [CNT_W-1:0] NOM_96K  = 10'd256;
    localparam logic [CNT_W-1:0] NOM_192K = 10'd128;

    typedef enum logic [1:0] {
        RATE_NONE = 2'b00,
        RATE_48K  = 2'b01,
        RATE_96K  = 2'b10,
        RATE_192K = 2'b11
    } rate_t;

    typedef enum logic [1:0] {
        ST_NOSIG   = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_t;

    function automatic logic near_nominal(input logic [CNT_W-1:0] p,
                                          input logic [CNT_W-1:0] nom,
                                          input int               tol);
        int d;
        d = int'(p) - int'(nom);
        if (d < 0) d = -d;
        return (d <= tol);
    endfunction

    // Bands stay disjoint as long as tol is well below 64.
    function automatic rate_t classify(input logic [CNT_W-1:0] p,
                                       input int               tol);
        rate_t r;
        r = RATE_NONE;
        if (near_nominal(p, NOM_48K, tol))       r = RATE_48K;
        else if (near_nominal(p, NOM_96K, tol))  r = RATE_96K;
        else if (near_nominal(p, NOM_192K, tol)) r = RATE_192K;
        return r;
    endfunction

endpackage

// File: rtl/dmix_sync2.sv
// Two-flop synchroniser bringing the asynchronous LRCK into the
// clk245760 domain.
module dmix_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dmix_rate_detect.sv
// Measures LRCK period in clk245760 cycles and locks onto 48/96/192 kHz.
// Optional: define DMIX_RATE_PERIOD_OUT_EN to export the last latched period.
module dmix_rate_detect
    import dmix_rate_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_COUNT = 2,
    parameter int TOL        = 8
) (
    input  logic             clk245760,
    input  logic             rst_n,
    input  logic             lrck,
    output logic [1:0]       rate,
    output logic             locked,
    output logic             rate_change,
`ifdef DMIX_RATE_PERIOD_OUT_EN
    output logic [CNT_W-1:0] period,
`endif
    output logic [1:0]       dbg_state_o
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int XW = $clog2(MISS_COUNT + 1);

    logic             lrck_s;
    logic             lrck_prev_q;
    logic             edge_w;
    logic             timeout_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rate_t            cls_w;

    state_t           state_q, state_d;
    rate_t            cand_q, cand_d;
    logic [MW-1:0]    match_q, match_d;
    logic [XW-1:0]    miss_q, miss_d;
    rate_t            rate_q, rate_d;
    logic             locked_q, locked_d;
    logic             rate_change_q, rate_change_d;

    dmix_sync2 u_sync (
        .clk_i   (clk245760),
        .rst_n_i (rst_n),
        .d_i     (lrck),
        .q_o     (lrck_s)
    );

    assign edge_w    = lrck_s & ~lrck_prev_q;
    // A saturated counter only times out when no edge arrives this cycle;
    // an edge here latches 1023, which classifies as no rate.
    assign timeout_w = (cnt_q == CNT_MAX) & ~edge_w;
    assign cls_w     = classify(cnt_q, TOL);

    always_comb begin
        cnt_d = cnt_q;
        if (edge_w)                cnt_d = 10'd1;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 10'd1;
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
        miss_d  = miss_q;
        if (edge_w) begin
            case (state_q)
                ST_NOSIG: begin
                    state_d = ST_ACQUIRE;
                    match_d = '0;
                    miss_d  = '0;
                    cand_d  = RATE_NONE;
                end
                ST_ACQUIRE: begin
                    if (cls_w == RATE_NONE) begin
                        match_d = '0;
                    end else if (cls_w == cand_q) begin
                        match_d = match_q + MW'(1);
                    end else begin
                        cand_d  = cls_w;
                        match_d = MW'(1);
                    end
                    if (match_d == MW'(LOCK_COUNT)) begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (cls_w == cand_q) miss_d = '0;
                    else                 miss_d = miss_q + XW'(1);
                    if (miss_d == XW'(MISS_COUNT)) begin
                        state_d = ST_ACQUIRE;
                        match_d = '0;
                        miss_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_NOSIG;
                end
            endcase
        end else if (timeout_w) begin
            state_d = ST_NOSIG;
            cand_d  = RATE_NONE;
            match_d = '0;
            miss_d  = '0;
        end
    end

    // Outputs follow the next state so they register in the same cycle as it.
    always_comb begin
        locked_d      = (state_d == ST_LOCKED);
        rate_d        = locked_d ? cand_d : RATE_NONE;
        rate_change_d = (rate_d != rate_q);
    end

    always_ff @(posedge clk245760 or negedge rst_n) begin
        if (!rst_n) begin
            lrck_prev_q   <= 1'b0;
            cnt_q         <= '0;
            state_q       <= ST_NOSIG;
            cand_q        <= RATE_NONE;
            match_q       <= '0;
            miss_q        <= '0;
            rate_q        <= RATE_NONE;
            locked_q      <= 1'b0;
            rate_change_q <= 1'b0;
        end else begin
            lrck_prev_q   <= lrck_s;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            rate_q        <= rate_d;
            locked_q      <= locked_d;
            rate_change_q <= rate_change_d;
        end
    end

`ifdef DMIX_RATE_PERIOD_OUT_EN
    logic [CNT_W-1:0] period_q;

    always_ff @(posedge clk245760 or negedge rst_n) begin
        if (!rst_n)      period_q <= '0;
        else if (edge_w) period_q <= cnt_q;
    end

    assign period = period_q;
`endif

    assign rate        = rate_q;
    assign locked      = locked_q;
    assign rate_change = rate_change_q;
    assign dbg_state_o = state_q;

endmodule
